// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit sitting beside the ALU in EX.
// Owns the architectural HI/LO registers. MULT/MULTU use a shift-add loop,
// DIV/DIVU a restoring-division loop, both on operand magnitudes with the
// sign applied in a final FIX cycle. MTHI/MTLO write HI/LO directly from idle.
//
// Ports
//   Clk         rising-edge clock
//   Reset_L     synchronous active-low reset
//   Start       op request, sampled only while idle
//   MulDivCtrl  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   BusA/BusB   rs / rt operands
//   Abort       cancels an in-flight op (pipeline flush)
//   Busy        op in progress (hazard-unit stall)
//   Done        one-cycle pulse after HI/LO are written
//   Hi/Lo       HI/LO registers
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for Start; MTHI/MTLO complete here in one edge
// S_MUL  | one shift-add step per edge, WIDTH steps
// S_DIV  | one restoring-division step per edge, WIDTH steps
// S_FIX  | sign correction, HI/LO write, Done pulse, back to idle
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset_L,
   input  logic             Start,
   input  logic [2:0]       MulDivCtrl,
   input  logic [WIDTH-1:0] BusA,
   input  logic [WIDTH-1:0] BusB,
   input  logic             Abort,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH-1:0]   dvd_q, dvd_d;
   logic               is_div_q, is_div_d;
   logic               neg_q, neg_d;
   logic               neg_rem_q, neg_rem_d;
   logic               dbz_q, dbz_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               a_sgn, b_sgn;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_rem_sh;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   // Bit 0 of the opcode distinguishes the unsigned variants of MULT/DIV.
   assign a_sgn = ~MulDivCtrl[0] & BusA[WIDTH-1];
   assign b_sgn = ~MulDivCtrl[0] & BusB[WIDTH-1];
   assign a_mag = a_sgn ? -BusA : BusA;
   assign b_mag = b_sgn ? -BusB : BusB;

   // Multiply: acc holds {partial product, remaining multiplier bits}.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide: acc holds {partial remainder, dividend/quotient bits}. The
   // shifted remainder can exceed WIDTH bits, hence the extra MSB.
   assign div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff   = div_rem_sh - {1'b0, opb_q};
   assign div_ge     = div_rem_sh >= {1'b0, opb_q};
   assign div_next   = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                              : {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

   assign prod_fix = neg_q     ? -acc_q : acc_q;
   assign quo_fix  = neg_q     ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      dvd_d     = dvd_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      dbz_d     = dbz_q;
      done_d    = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         S_IDLE: begin
            if (Start && !Abort) begin
               case (MulDivCtrl)
                  3'b000, 3'b001: begin
                     state_d  = S_MUL;
                     cnt_d    = '0;
                     acc_d    = {{WIDTH{1'b0}}, b_mag};
                     opb_d    = a_mag;
                     neg_d    = a_sgn ^ b_sgn;
                     is_div_d = 1'b0;
                  end
                  3'b010, 3'b011: begin
                     state_d   = S_DIV;
                     cnt_d     = '0;
                     acc_d     = {{WIDTH{1'b0}}, a_mag};
                     opb_d     = b_mag;
                     dvd_d     = BusA;
                     neg_d     = a_sgn ^ b_sgn;
                     neg_rem_d = a_sgn;
                     dbz_d     = (BusB == '0);
                     is_div_d  = 1'b1;
                  end
                  3'b100: begin
                     hi_d   = BusA;
                     done_d = 1'b1;
                  end
                  3'b101: begin
                     lo_d   = BusA;
                     done_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         S_MUL, S_DIV: begin
            if (Abort) begin
               state_d = S_IDLE;
            end else begin
               acc_d = (state_q == S_MUL) ? mul_next : div_next;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (!Abort) begin
               done_d = 1'b1;
               if (!is_div_q) begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end else if (dbz_q) begin
                  // Divide by zero reports all-ones quotient and the raw dividend.
                  hi_d = dvd_q;
                  lo_d = '1;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_L) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opb_q     <= '0;
         dvd_q     <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         dvd_q     <= dvd_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         dbz_q     <= dbz_d;
         done_q    <= done_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign Busy = (state_q != S_IDLE);
   assign Done = done_q;
   assign Hi   = hi_q;
   assign Lo   = lo_q;

endmodule
